tdm_demultiplexer: RTL and testbench

Time-division demultiplexer: accepts a word-serial TDM stream, one word per slot with a frame-sync marker on slot 0, and routes each word into a per-channel holding register. It is the receive-side counterpart of the lab's selector/multiplexer datapath. It sits between a shared serial word bus and per-channel consumers. It tracks frame alignment with a hunt/lock state machine, flywheels through occasional missing syncs, and flags misaligned syncs.

---
 rtl/tdm_demultiplexer.sv | 155 +++++++++++++++
 tb/tb_tdm_demultiplexer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demultiplexer.sv
// rtl/tdm_demultiplexer.sv - word-serial TDM receive demultiplexer with hunt/lock frame alignment
module tdm_demultiplexer #(
  parameter int NUM_CHANNELS = 4,
  parameter int WIDTH        = 8,
  parameter int MAX_MISS     = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          din_valid,
  input  logic                          sync,
  input  logic [WIDTH-1:0]              din,
  output logic [NUM_CHANNELS*WIDTH-1:0] dout,
  output logic [NUM_CHANNELS-1:0]       ch_valid,
  output logic                          frame_done,
  output logic                          locked,
  output logic                          sync_err
);

  localparam int SW = $clog2(NUM_CHANNELS);
  // Miss counter must hold MAX_MISS+1 so the overflow compare is exact.
  localparam int MW = $clog2(MAX_MISS + 2);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CHANNELS - 1);
  localparam logic [SW-1:0] FIRST_AFTER_SYNC = SW'(1);
  localparam logic [MW-1:0] MISS_LIMIT = MW'(MAX_MISS);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [SW-1:0]                 slot_cnt_q, slot_cnt_d;
  logic [MW-1:0]                 miss_cnt_q, miss_cnt_d;
  logic                          frame_ok_q, frame_ok_d;
  logic [NUM_CHANNELS*WIDTH-1:0] dout_q, dout_d;
  logic [NUM_CHANNELS-1:0]       ch_valid_q, ch_valid_d;
  logic                          frame_done_q, frame_done_d;
  logic                          locked_q, locked_d;
  logic                          sync_err_q, sync_err_d;

  logic                          wr_en;
  logic [SW-1:0]                 wr_slot;
  logic [MW-1:0]                 miss_inc;

  // Alignment FSM: decide the next state, counters, which slot gets written, and strobes.
  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    frame_ok_d   = frame_ok_q;
    dout_d       = dout_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    wr_en        = 1'b0;
    wr_slot      = '0;
    miss_inc     = miss_cnt_q + MW'(1);

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            wr_en      = 1'b1;
            wr_slot    = '0;
            slot_cnt_d = FIRST_AFTER_SYNC;
            miss_cnt_d = '0;
            frame_ok_d = 1'b1;
            state_d    = LOCK;
          end
        end
        LOCK: begin
          if (sync) begin
            // A sync anywhere but slot 0 realigns and abandons the current frame.
            if (slot_cnt_q != '0) begin
              sync_err_d = 1'b1;
            end else begin
              miss_cnt_d = '0;
            end
            wr_en      = 1'b1;
            wr_slot    = '0;
            slot_cnt_d = FIRST_AFTER_SYNC;
            frame_ok_d = 1'b1;
          end else if (slot_cnt_q == '0) begin
            // Missing sync at slot 0: flywheel until the tolerance is exceeded.
            if (miss_inc > MISS_LIMIT) begin
              state_d    = HUNT;
              slot_cnt_d = '0;
              miss_cnt_d = '0;
              frame_ok_d = 1'b0;
            end else begin
              miss_cnt_d = miss_inc;
              wr_en      = 1'b1;
              wr_slot    = '0;
              slot_cnt_d = FIRST_AFTER_SYNC;
              frame_ok_d = 1'b1;
            end
          end else begin
            wr_en   = 1'b1;
            wr_slot = slot_cnt_q;
            // Explicit wrap so non-power-of-two channel counts never overrun.
            if (slot_cnt_q == LAST_SLOT) begin
              slot_cnt_d   = '0;
              frame_done_d = frame_ok_q;
              frame_ok_d   = 1'b0;
            end else begin
              slot_cnt_d = slot_cnt_q + FIRST_AFTER_SYNC;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    if (wr_en) begin
      dout_d[wr_slot*WIDTH +: WIDTH] = din;
      ch_valid_d[wr_slot]            = 1'b1;
    end

    locked_d = (state_d == LOCK);
  end

  // State, counters, holding registers and strobes; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      slot_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      frame_ok_q   <= 1'b0;
      dout_q       <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      frame_ok_q   <= frame_ok_d;
      dout_q       <= dout_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout       = dout_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// tb/tb_tdm_demultiplexer.sv - directed self-checking bench for tdm_demultiplexer
module tb_tdm_demultiplexer;

  logic        clk;
  logic        reset_n;
  logic        din_valid;
  logic        sync;
  logic [7:0]  din;
  logic [31:0] dout;
  logic [3:0]  ch_valid;
  logic        frame_done;
  logic        locked;
  logic        sync_err;

  int vectors;
  int miscompares;

  tdm_demultiplexer #(
    .NUM_CHANNELS(4),
    .WIDTH(8),
    .MAX_MISS(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .din_valid(din_valid),
    .sync(sync),
    .din(din),
    .dout(dout),
    .ch_valid(ch_valid),
    .frame_done(frame_done),
    .locked(locked),
    .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive on the falling edge, leave outputs settled 1ns after the rising edge.
  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = 8'h00;
    reset_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 8'hFF);
      vectors++;
      if (dout !== 32'h0 || ch_valid !== 4'h0 || locked !== 1'b0 ||
          frame_done !== 1'b0 || sync_err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: dout=%h ch_valid=%b locked=%b fd=%b se=%b, required all zero",
                 i, dout, ch_valid, locked, frame_done, sync_err);
      end
    end
  endtask

  task automatic test_hunt_frame();
    logic [7:0] junk [3];
    logic [3:0] exp_cv [4];
    junk = '{8'h55, 8'h66, 8'h77};
    exp_cv = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, junk[i]);
      vectors++;
      if (ch_valid !== 4'h0 || locked !== 1'b0 || dout !== 32'h0) begin
        miscompares++;
        $display("FAIL hunt_ignore %0d: ch_valid=%b locked=%b dout=%h, required 0000/0/0",
                 i, ch_valid, locked, dout);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), 8'hA0 + 8'(i));
      vectors++;
      if (ch_valid !== exp_cv[i] || locked !== 1'b1 || frame_done !== (i == 3) || sync_err !== 1'b0) begin
        miscompares++;
        $display("FAIL hunt_frame slot %0d: ch_valid=%b locked=%b fd=%b se=%b, required %b/1/%0d/0",
                 i, ch_valid, locked, frame_done, sync_err, exp_cv[i], (i == 3));
      end
    end
    vectors++;
    if (dout !== 32'hA3A2A1A0) begin
      miscompares++;
      $display("FAIL hunt_frame_dout: got %h required a3a2a1a0", dout);
    end
  endtask

  task automatic test_gaps();
    int fd_cnt;
    int se_cnt;
    fd_cnt = 0;
    se_cnt = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), 8'hA0 + 8'(i));
      fd_cnt += frame_done;
      se_cnt += sync_err;
      for (int g = 0; g < 2; g++) begin
        drive(1'b0, 1'b0, 8'hEE);
        fd_cnt += frame_done;
        se_cnt += sync_err;
        vectors++;
        if (ch_valid !== 4'h0 || locked !== 1'b1) begin
          miscompares++;
          $display("FAIL gap_hold slot %0d gap %0d: ch_valid=%b locked=%b, required 0000/1",
                   i, g, ch_valid, locked);
        end
      end
    end
    vectors++;
    if (dout !== 32'hA3A2A1A0 || fd_cnt != 1 || se_cnt != 0) begin
      miscompares++;
      $display("FAIL gaps_frame: dout=%h fd_count=%0d se_count=%0d, required a3a2a1a0/1/0",
               dout, fd_cnt, se_cnt);
    end
  endtask

  task automatic test_misaligned_sync();
    int fd_cnt;
    int se_cnt;
    fd_cnt = 0;
    se_cnt = 0;
    do_reset();
    drive(1'b1, 1'b1, 8'h10);
    fd_cnt += frame_done; se_cnt += sync_err;
    drive(1'b1, 1'b0, 8'h11);
    fd_cnt += frame_done; se_cnt += sync_err;
    drive(1'b1, 1'b1, 8'h20);
    fd_cnt += frame_done; se_cnt += sync_err;
    vectors++;
    if (sync_err !== 1'b1 || ch_valid !== 4'b0001) begin
      miscompares++;
      $display("FAIL misalign_strobe: sync_err=%b ch_valid=%b, required 1/0001", sync_err, ch_valid);
    end
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h20 + 8'(i));
      fd_cnt += frame_done; se_cnt += sync_err;
    end
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_last_fd: frame_done=%b required 1", frame_done);
    end
    vectors++;
    if (dout !== 32'h23222120 || fd_cnt != 1 || se_cnt != 1) begin
      miscompares++;
      $display("FAIL misalign_totals: dout=%h fd_count=%0d se_count=%0d, required 23222120/1/1",
               dout, fd_cnt, se_cnt);
    end
  endtask

  task automatic test_flywheel();
    int fd_cnt;
    fd_cnt = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), 8'h30 + 8'(i));
      fd_cnt += frame_done;
    end
    for (int f = 1; f <= 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 1'b0, 8'h30 + 8'(f * 16 + i));
        fd_cnt += frame_done;
        vectors++;
        if (locked !== 1'b1 || ch_valid !== (4'b0001 << i)) begin
          miscompares++;
          $display("FAIL flywheel frame %0d slot %0d: locked=%b ch_valid=%b, required 1/%b",
                   f, i, locked, ch_valid, 4'b0001 << i);
        end
      end
    end
    vectors++;
    if (dout !== 32'h53525150 || fd_cnt != 3) begin
      miscompares++;
      $display("FAIL flywheel_totals: dout=%h fd_count=%0d, required 53525150/3", dout, fd_cnt);
    end
    drive(1'b1, 1'b0, 8'h60);
    vectors++;
    if (locked !== 1'b0 || ch_valid !== 4'h0 || frame_done !== 1'b0 || dout !== 32'h53525150) begin
      miscompares++;
      $display("FAIL lock_loss: locked=%b ch_valid=%b fd=%b dout=%h, required 0/0000/0/53525150",
               locked, ch_valid, frame_done, dout);
    end
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h60 + 8'(i));
      vectors++;
      if (locked !== 1'b0 || ch_valid !== 4'h0 || dout !== 32'h53525150) begin
        miscompares++;
        $display("FAIL post_loss_ignore %0d: locked=%b ch_valid=%b dout=%h, required 0/0000/53525150",
                 i, locked, ch_valid, dout);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b1, 8'h70);
    drive(1'b1, 1'b0, 8'h71);
    vectors++;
    if (ch_valid !== 4'b0010 || dout !== 32'h00007170 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: ch_valid=%b dout=%h locked=%b, required 0010/00007170/1",
               ch_valid, dout, locked);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (dout !== 32'h0 || locked !== 1'b0 || ch_valid !== 4'h0 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_clear: dout=%h locked=%b ch_valid=%b fd=%b se=%b, required all zero",
               dout, locked, ch_valid, frame_done, sync_err);
    end
    din_valid = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 8'h72);
    vectors++;
    if (dout !== 32'h0 || locked !== 1'b0 || ch_valid !== 4'h0) begin
      miscompares++;
      $display("FAIL post_reset_ignore: dout=%h locked=%b ch_valid=%b, required 0/0/0000",
               dout, locked, ch_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    din_valid   = 1'b0;
    sync        = 1'b0;
    din         = 8'h00;
    #1;
    vectors++;
    if (dout !== 32'h0 || locked !== 1'b0 || ch_valid !== 4'h0) begin
      miscompares++;
      $display("FAIL initial_reset: dout=%h locked=%b ch_valid=%b, required 0/0/0000", dout, locked, ch_valid);
    end
    test_reset();
    test_hunt_frame();
    test_gaps();
    test_misaligned_sync();
    test_flywheel();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
